// File: rtl/dirty_sector_map.sv
// Dirty-sector tracking map with a flush engine that scans the map, offers each
// dirty entry to storage and clears it on acknowledge until the whole map is clean.
module dirty_sector_map #(
  parameter int unsigned NUM_SECTORS = 64,
  parameter int unsigned NUM_HEADS   = 2,
  localparam int unsigned N  = NUM_SECTORS * NUM_HEADS,
  localparam int unsigned SW = $clog2(NUM_SECTORS),
  localparam int unsigned HW = (NUM_HEADS > 1) ? $clog2(NUM_HEADS) : 1,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          mark_en_i,
  input  logic [HW-1:0] mark_head_i,
  input  logic [SW-1:0] mark_sector_i,
  input  logic          mark_d_i,
  input  logic          flush_start_i,
  input  logic          flush_abort_i,
  output logic          flush_valid_o,
  output logic [HW-1:0] flush_head_o,
  output logic [SW-1:0] flush_sector_o,
  input  logic          flush_ack_i,
  output logic          flush_busy_o,
  output logic          flush_done_o,
  output logic [N-1:0]  dirty_map_o,
  output logic [CW-1:0] dirty_count_o,
  output logic          all_clean_o
);

  localparam int unsigned PW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StSearch, StOffer, StDone} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  map_q, map_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] head_q, head_d;
  logic [SW-1:0] sector_q, sector_d;

  logic          mark_ok;
  logic [PW-1:0] mark_idx;
  logic          ack_apply;
  logic          ptr_adv;
  logic          ptr_rst;
  logic          all_clean;

  assign all_clean = ~|map_q;
  assign mark_ok   = mark_en_i && (32'(mark_sector_i) < NUM_SECTORS)
                     && (32'(mark_head_i) < NUM_HEADS);
  assign mark_idx  = PW'(32'(mark_head_i) * NUM_SECTORS + 32'(mark_sector_i));
  // Abort outranks a same-cycle ack, so the offered entry keeps its dirty bit.
  assign ack_apply = (state_q == StOffer) && flush_ack_i && !flush_abort_i;

  always_comb begin
    state_d = state_q;
    ptr_adv = 1'b0;
    ptr_rst = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_start_i) begin
          state_d = StSearch;
          ptr_rst = 1'b1;
        end
      end
      StSearch: begin
        if (flush_abort_i) begin
          state_d = StIdle;
        end else if (all_clean) begin
          state_d = StDone;
        end else if (map_q[ptr_q]) begin
          state_d = StOffer;
        end else begin
          ptr_adv = 1'b1;
        end
      end
      StOffer: begin
        if (flush_abort_i) begin
          state_d = StIdle;
        end else if (flush_ack_i) begin
          state_d = StSearch;
          ptr_adv = 1'b1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Linear index plus a head/sector pair advanced in lockstep, so no divider is needed.
  always_comb begin
    ptr_d    = ptr_q;
    head_d   = head_q;
    sector_d = sector_q;
    if (ptr_rst) begin
      ptr_d    = '0;
      head_d   = '0;
      sector_d = '0;
    end else if (ptr_adv) begin
      ptr_d = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
      if (sector_q == SW'(NUM_SECTORS - 1)) begin
        sector_d = '0;
        head_d   = (head_q == HW'(NUM_HEADS - 1)) ? '0 : head_q + HW'(1);
      end else begin
        sector_d = sector_q + SW'(1);
      end
    end
  end

  // Mark is applied after the ack clear so a same-entry set-dirty wins.
  always_comb begin
    map_d = map_q;
    if (ack_apply) begin
      map_d[ptr_q] = 1'b0;
    end
    if (mark_ok) begin
      map_d[mark_idx] = mark_d_i;
    end
    count_d = count_q;
    if (ack_apply && (map_q[ptr_q] != map_d[ptr_q])) begin
      count_d = map_d[ptr_q] ? count_d + CW'(1) : count_d - CW'(1);
    end
    if (mark_ok && !(ack_apply && (mark_idx == ptr_q))
        && (map_q[mark_idx] != map_d[mark_idx])) begin
      count_d = map_d[mark_idx] ? count_d + CW'(1) : count_d - CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= StIdle;
      map_q    <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      head_q   <= '0;
      sector_q <= '0;
    end else begin
      state_q  <= state_d;
      map_q    <= map_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      head_q   <= head_d;
      sector_q <= sector_d;
    end
  end

  assign flush_valid_o  = (state_q == StOffer);
  assign flush_head_o   = head_q;
  assign flush_sector_o = sector_q;
  assign flush_busy_o   = (state_q != StIdle);
  assign flush_done_o   = (state_q == StDone) && !flush_abort_i;
  assign dirty_map_o    = map_q;
  assign dirty_count_o  = count_q;
  assign all_clean_o    = all_clean;

endmodule

// File: tb/tb_dirty_sector_map.sv
// Scoreboard bench: stimulus queues expected offers/done pulses, a monitor checks them.
module tb_dirty_sector_map;

  logic clk;
  logic reset_n;

  // Instance A: 64 sectors x 2 heads (N = 128)
  logic         a_mark_en, a_md, a_start, a_abort, a_ack;
  logic [0:0]   a_head;
  logic [5:0]   a_sector;
  logic         a_valid, a_busy, a_done, a_clean;
  logic [0:0]   a_fhead;
  logic [5:0]   a_fsector;
  logic [127:0] a_map;
  logic [7:0]   a_count;

  // Instance B: 12 sectors x 3 heads (N = 36)
  logic         b_mark_en, b_md, b_start, b_abort, b_ack;
  logic [1:0]   b_head;
  logic [3:0]   b_sector;
  logic         b_valid, b_busy, b_done, b_clean;
  logic [1:0]   b_fhead;
  logic [3:0]   b_fsector;
  logic [35:0]  b_map;
  logic [5:0]   b_count;

  dirty_sector_map u_dut_a (
    .clk_i(clk), .reset_ni(reset_n),
    .mark_en_i(a_mark_en), .mark_head_i(a_head), .mark_sector_i(a_sector), .mark_d_i(a_md),
    .flush_start_i(a_start), .flush_abort_i(a_abort),
    .flush_valid_o(a_valid), .flush_head_o(a_fhead), .flush_sector_o(a_fsector),
    .flush_ack_i(a_ack), .flush_busy_o(a_busy), .flush_done_o(a_done),
    .dirty_map_o(a_map), .dirty_count_o(a_count), .all_clean_o(a_clean)
  );

  dirty_sector_map #(.NUM_SECTORS(12), .NUM_HEADS(3)) u_dut_b (
    .clk_i(clk), .reset_ni(reset_n),
    .mark_en_i(b_mark_en), .mark_head_i(b_head), .mark_sector_i(b_sector), .mark_d_i(b_md),
    .flush_start_i(b_start), .flush_abort_i(b_abort),
    .flush_valid_o(b_valid), .flush_head_o(b_fhead), .flush_sector_o(b_fsector),
    .flush_ack_i(b_ack), .flush_busy_o(b_busy), .flush_done_o(b_done),
    .dirty_map_o(b_map), .dirty_count_o(b_count), .all_clean_o(b_clean)
  );

  typedef struct {
    bit is_done;
    int head;
    int sector;
  } ev_t;

  ev_t qa[$];
  ev_t qb[$];
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic ev_t offer(input int h, input int s);
    ev_t e;
    e.is_done = 1'b0;
    e.head = h;
    e.sector = s;
    return e;
  endfunction

  function automatic ev_t done_ev();
    ev_t e;
    e.is_done = 1'b1;
    e.head = 0;
    e.sector = 0;
    return e;
  endfunction

  function automatic bit sig(input int which);
    case (which)
      0: return a_valid;
      1: return a_done;
      2: return b_valid;
      default: return b_done;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      @(negedge clk);
      hit = sig(which);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles, event required", name, bound);
    end
  endtask

  task automatic mark(input int which, input int h, input int s, input bit d);
    @(negedge clk);
    if (which == 0) begin
      a_mark_en = 1'b1; a_head = 1'(h); a_sector = 6'(s); a_md = d;
    end else begin
      b_mark_en = 1'b1; b_head = 2'(h); b_sector = 4'(s); b_md = d;
    end
    @(negedge clk);
    a_mark_en = 1'b0;
    b_mark_en = 1'b0;
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) a_start = 1'b1; else b_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  // One cycle after the offer is seen, ack it for one cycle.
  task automatic ack_a();
    @(negedge clk);
    a_ack = 1'b1;
    @(negedge clk);
    a_ack = 1'b0;
  endtask

  // Monitor: pops expectations on each new offer and each done pulse.
  initial begin
    bit a_prev = 1'b0;
    bit b_prev = 1'b0;
    ev_t e;
    forever begin
      @(negedge clk);
      if (a_valid && !a_prev) begin
        if (qa.size() == 0) chk("a unexpected offer", {a_fhead, a_fsector}, 0);
        else begin
          e = qa.pop_front();
          chk("a event is offer", 0, e.is_done);
          chk("a offer head", a_fhead, e.head);
          chk("a offer sector", a_fsector, e.sector);
        end
      end
      if (a_done) begin
        if (qa.size() == 0) chk("a unexpected done", a_done, 0);
        else begin
          e = qa.pop_front();
          chk("a event is done", 1, e.is_done);
        end
      end
      if (b_valid && !b_prev) begin
        if (qb.size() == 0) chk("b unexpected offer", {b_fhead, b_fsector}, 0);
        else begin
          e = qb.pop_front();
          chk("b event is offer", 0, e.is_done);
          chk("b offer head", b_fhead, e.head);
          chk("b offer sector", b_fsector, e.sector);
        end
      end
      if (b_done) begin
        if (qb.size() == 0) chk("b unexpected done", b_done, 0);
        else begin
          e = qb.pop_front();
          chk("b event is done", 1, e.is_done);
        end
      end
      a_prev = a_valid;
      b_prev = b_valid;
    end
  end

  initial begin
    logic [127:0] exp_map;
    reset_n = 1'b0;
    {a_mark_en, a_md, a_start, a_abort, a_ack, a_head, a_sector} = '0;
    {b_mark_en, b_md, b_start, b_abort, b_ack, b_head, b_sector} = '0;
    #1;
    chk("reset count", a_count, 0);
    chk("reset all_clean", a_clean, 1);
    chk("reset busy", a_busy, 0);
    chk("reset valid", a_valid, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Basic marks: one-cycle latency
    mark(0, 0, 5, 1'b1);
    chk("mark latency count", a_count, 1);
    mark(0, 1, 63, 1'b1);
    exp_map = '0; exp_map[5] = 1'b1; exp_map[127] = 1'b1;
    chk("map bits 5,127", a_map, exp_map);
    chk("count 2", a_count, 2);
    chk("all_clean low", a_clean, 0);

    // Flush of two entries
    qa.push_back(offer(0, 5)); qa.push_back(offer(1, 63)); qa.push_back(done_ev());
    pulse_start(0);
    wait_for(0, 300, "offer 0/5");
    ack_a();
    chk("count after first ack", a_count, 1);
    wait_for(0, 300, "offer 1/63");
    ack_a();
    wait_for(1, 10, "done pass1");
    chk("count at done", a_count, 0);
    chk("busy at done", a_busy, 1);
    @(negedge clk);
    chk("done one cycle", a_done, 0);
    chk("busy after done", a_busy, 0);

    // Re-dirty in ack cycle: wraps and re-offers
    mark(0, 0, 10, 1'b1);
    qa.push_back(offer(0, 10)); qa.push_back(offer(0, 10)); qa.push_back(done_ev());
    pulse_start(0);
    wait_for(0, 300, "offer 0/10");
    @(negedge clk);
    a_ack = 1'b1; a_mark_en = 1'b1; a_head = 1'b0; a_sector = 6'd10; a_md = 1'b1;
    @(negedge clk);
    a_ack = 1'b0; a_mark_en = 1'b0;
    chk("redirty bit 10", a_map[10], 1);
    chk("redirty count", a_count, 1);
    wait_for(0, 300, "re-offer 0/10");
    ack_a();
    wait_for(1, 10, "done pass2");
    chk("count pass2", a_count, 0);

    // Ack and mark on different entries net in one cycle
    mark(0, 0, 20, 1'b1);
    mark(0, 0, 30, 1'b1);
    qa.push_back(offer(0, 20)); qa.push_back(offer(0, 30)); qa.push_back(offer(0, 40));
    qa.push_back(done_ev());
    pulse_start(0);
    wait_for(0, 300, "offer 0/20");
    @(negedge clk);
    a_ack = 1'b1; a_mark_en = 1'b1; a_head = 1'b0; a_sector = 6'd40; a_md = 1'b1;
    @(negedge clk);
    a_ack = 1'b0; a_mark_en = 1'b0;
    exp_map = '0; exp_map[30] = 1'b1; exp_map[40] = 1'b1;
    chk("net map", a_map, exp_map);
    chk("net count", a_count, 2);
    wait_for(0, 300, "offer 0/30");
    ack_a();
    wait_for(0, 300, "offer 0/40");
    ack_a();
    wait_for(1, 10, "done pass3");

    // Mark-clean of the offered entry
    mark(0, 1, 0, 1'b1);
    qa.push_back(offer(1, 0)); qa.push_back(done_ev());
    pulse_start(0);
    wait_for(0, 300, "offer 1/0");
    mark(0, 1, 0, 1'b0);
    chk("clean-in-offer count", a_count, 0);
    chk("clean-in-offer valid", a_valid, 1);
    ack_a();
    chk("ack after clean count", a_count, 0);
    wait_for(1, 10, "done pass4");

    // Abort with same-cycle ack
    mark(0, 1, 2, 1'b1);
    qa.push_back(offer(1, 2));
    pulse_start(0);
    wait_for(0, 300, "offer 1/2");
    @(negedge clk);
    a_ack = 1'b1; a_abort = 1'b1;
    @(negedge clk);
    a_ack = 1'b0; a_abort = 1'b0;
    chk("abort busy", a_busy, 0);
    chk("abort valid", a_valid, 0);
    chk("abort bit 66", a_map[66], 1);
    chk("abort count", a_count, 1);
    repeat (5) @(negedge clk);
    a_ack = 1'b1;
    @(negedge clk);
    a_ack = 1'b0;
    chk("idle ack ignored", a_count, 1);

    // Reset during an offer with three dirty entries
    mark(0, 0, 1, 1'b1);
    mark(0, 0, 2, 1'b1);
    chk("three dirty", a_count, 3);
    qa.push_back(offer(0, 1));
    pulse_start(0);
    wait_for(0, 300, "offer 0/1");
    #2 reset_n = 1'b0;
    #1;
    chk("async rst map", a_map, 0);
    chk("async rst count", a_count, 0);
    chk("async rst clean", a_clean, 1);
    chk("async rst valid", a_valid, 0);
    chk("async rst busy", a_busy, 0);
    chk("async rst done", a_done, 0);
    chk("async rst head", a_fhead, 0);
    chk("async rst sector", a_fsector, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Instance B: 12x3 geometry
    mark(1, 0, 13, 1'b1);
    chk("b sector 13 ignored", b_count, 0);
    mark(1, 3, 0, 1'b1);
    chk("b head 3 ignored", b_count, 0);
    mark(1, 2, 11, 1'b1);
    exp_map = '0; exp_map[35] = 1'b1;
    chk("b bit 35", b_map, exp_map);
    qb.push_back(offer(2, 11)); qb.push_back(offer(0, 0)); qb.push_back(done_ev());
    pulse_start(1);
    wait_for(2, 60, "b offer 2/11");
    @(negedge clk);
    b_ack = 1'b1; b_mark_en = 1'b1; b_head = 2'd0; b_sector = 4'd0; b_md = 1'b1;
    @(negedge clk);
    b_ack = 1'b0; b_mark_en = 1'b0;
    chk("b count after ack", b_count, 1);
    wait_for(2, 3, "b wrap to 0");
    @(negedge clk);
    b_ack = 1'b1;
    @(negedge clk);
    b_ack = 1'b0;
    wait_for(3, 10, "b done");
    chk("b count at done", b_count, 0);

    repeat (3) @(negedge clk);
    chk("a events drained", qa.size(), 0);
    chk("b events drained", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dirty_sector_map.md
DIRTY_SECTOR_MAP -- requirements
Module: dirty_sector_map

Interface
REQ-001 SHALL have parameter NUM_SECTORS, default 64, sectors per track (2..256).
REQ-002 SHALL have parameter NUM_HEADS, default 2, heads per cylinder (1..16); N = NUM_SECTORS*NUM_HEADS entries; SW = clog2(NUM_SECTORS); HW = max(1, clog2(NUM_HEADS)).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: clk, reset_n.
REQ-004 clk  in  1  sole clock; all state on posedge clk.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 mark_en  in  1  update request for one entry this cycle.
REQ-007 mark_head  in  HW  head of entry to update.
REQ-008 mark_sector  in  SW  sector of entry to update.
REQ-009 mark_d  in  1  1 = set dirty, 0 = set clean.
REQ-010 flush_start  in  1  pulse: begin flush pass.
REQ-011 flush_abort  in  1  pulse: terminate flush pass.
REQ-012 flush_valid  out  1  entry offered to storage.
REQ-013 flush_head  out  HW  head of offered entry.
REQ-014 flush_sector  out  SW  sector of offered entry.
REQ-015 flush_ack  in  1  storage has written offered entry.
REQ-016 flush_busy  out  1  flush pass in progress.
REQ-017 flush_done  out  1  one-cycle pulse: pass completed with map clean.
REQ-018 dirty_map  out  N  bit (head*NUM_SECTORS + sector) = dirty.
REQ-019 dirty_count  out  clog2(N+1)  number of set bits in dirty_map.
REQ-020 all_clean  out  1  combinational NOR of dirty_map.

Function
REQ-021 Entry index SHALL be head*NUM_SECTORS + sector; mark requests with sector >= NUM_SECTORS or head >= NUM_HEADS SHALL be ignored.
REQ-022 A mark SHALL update dirty_map and dirty_count on the next clock edge (1-cycle latency); count SHALL stay equal to popcount(dirty_map) every cycle.
REQ-023 Flush FSM states: IDLE, SEARCH, OFFER, DONE.
REQ-024 IDLE: flush_start -> SEARCH with scan pointer ptr = 0; flush_start outside IDLE SHALL be ignored.
REQ-025 SEARCH: one entry examined per cycle; if all_clean -> DONE; else if dirty_map[ptr] -> OFFER; else ptr = (ptr+1) mod N.
REQ-026 OFFER: flush_valid = 1, flush_head/flush_sector decode ptr and SHALL hold stable until flush_ack.
REQ-027 OFFER with flush_ack: clear dirty_map[ptr], ptr = (ptr+1) mod N, -> SEARCH.
REQ-028 DONE: flush_done = 1 for exactly one cycle, -> IDLE.
REQ-029 flush_busy SHALL be 1 in SEARCH, OFFER, DONE; 0 in IDLE.
REQ-030 Pointer SHALL wrap N-1 -> 0; the pass ends only when the whole map is clean, so entries re-dirtied behind ptr are revisited.
REQ-031 Same-entry collision in one cycle: mark set-dirty wins over ack clear (entry stays dirty); mark clean and ack clear both clear, count decremented once.
REQ-032 A mark-clean of the entry currently in OFFER SHALL clear it; flush_valid stays 1 until flush_ack, and the ack then has no further map effect.
REQ-033 Simultaneous mark and ack on different entries SHALL both apply; dirty_count SHALL net both changes in the same cycle.
REQ-034 flush_abort in any non-IDLE state SHALL force IDLE next cycle, no flush_done, map untouched; abort has priority over a same-cycle ack (the offered entry stays dirty).
REQ-035 flush_ack outside OFFER SHALL be ignored.

Reset
REQ-036 On reset_n low, asynchronously: dirty_map = 0, dirty_count = 0, all_clean = 1, FSM = IDLE, ptr = 0, flush_valid = 0, flush_busy = 0, flush_done = 0, flush_head = 0, flush_sector = 0.
REQ-037 Reset mid-pass SHALL discard the pass and all dirty state; no flush_done.

Verification
REQ-038 Defaults; mark set h0/s5, h1/s63 -> dirty_map bits 5 and 127 set, dirty_count = 2, all_clean = 0 one cycle later.
REQ-039 Flush with bits 5,127 dirty, ack 1 cycle after each valid -> offers (0,5) then (1,63), then flush_done pulse, dirty_count = 0, flush_busy low next cycle.
REQ-040 Offer (0,10), re-mark h0/s10 dirty in ack cycle -> bit stays set, pass wraps and re-offers (0,10); second ack -> flush_done.
REQ-041 flush_abort while offering (1,2) with ack same cycle -> IDLE, bit 66 still set, no flush_done.
REQ-042 NUM_SECTORS=12, NUM_HEADS=3: mark s13 ignored; mark h2/s11 -> bit 35; flush offers (2,11), wrap from ptr 35 to 0 verified.
REQ-043 reset_n low during OFFER with 3 dirty entries -> all outputs at REQ-036 values immediately, before next clk edge.
